stamp_counter_mc: RTL and testbench

Parametrised successor to the single-channel time stamp counter.
- Runs entirely in one clock domain. Advances a fractional-rate (DDS) timestamp, accepts absolute time loads and rate updates, and emits a periodic sync snapshot for the correction loop.
- Provides NUM_CHANNELS independent event-capture channels, each with a valid/ack handshake and a sticky overrun flag.
- Sits between the NTP/correction logic and per-queue packet timestamping.

---
 rtl/stamp_counter_mc.sv | 152 +++++++++++++++
 tb/tb_stamp_counter_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stamp_counter_mc.sv
// Multi-channel DDS time stamp counter with periodic sync snapshot and per-channel event capture.
// Optional macro STAMP_CAP_SYNC_EN adds a 2-flop synchroniser on every cap_req bit.
module stamp_counter_mc #(
  parameter int                   TS_WIDTH     = 64,
  parameter int                   DROP_BITS    = 6,
  parameter int                   ACC_WIDTH    = 32,
  parameter logic [ACC_WIDTH-1:0] RATE_INIT    = 32'h80000000,
  parameter int                   SYNC_PERIOD  = 62500000,
  parameter int                   NUM_CHANNELS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_valid,
  input  logic [TS_WIDTH-1:0]              load_time,
  input  logic                             rate_valid,
  input  logic [ACC_WIDTH-1:0]             rate_in,
  output logic [TS_WIDTH-1:0]              counter_val,
  output logic                             sync_valid,
  output logic [TS_WIDTH-1:0]              sync_time,
  input  logic [NUM_CHANNELS-1:0]          cap_req,
  input  logic [NUM_CHANNELS-1:0]          cap_ack,
  output logic [NUM_CHANNELS-1:0]          cap_valid,
  output logic [NUM_CHANNELS*TS_WIDTH-1:0] cap_val,
  output logic [NUM_CHANNELS-1:0]          cap_overrun
);

  localparam int BODY_W = TS_WIDTH - DROP_BITS;
  localparam int SCNT_W = $clog2(SYNC_PERIOD);
  localparam logic [SCNT_W-1:0] SYNC_LAST = SCNT_W'(SYNC_PERIOD - 1);

  // Carry out of the phase add is the body increment, so an exact wrap to 0 still counts.
  function automatic logic [ACC_WIDTH:0] phase_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [BODY_W-1:0]               body_q, body_d;
  logic [ACC_WIDTH-1:0]            acc_q, acc_d;
  logic [ACC_WIDTH-1:0]            rate_q, rate_d;
  logic [ACC_WIDTH:0]              sum;
  logic [SCNT_W-1:0]               scnt_q, scnt_d;
  logic                            at_sync;
  logic                            sync_valid_q, sync_valid_d;
  logic [TS_WIDTH-1:0]             sync_time_q, sync_time_d;
  logic [NUM_CHANNELS-1:0]         req_s;
  logic [NUM_CHANNELS-1:0]         req_prev_q, req_prev_d;
  logic [NUM_CHANNELS-1:0]         cap_edge;
  logic [NUM_CHANNELS-1:0]         cap_valid_q, cap_valid_d;
  logic [NUM_CHANNELS-1:0]         cap_ovr_q, cap_ovr_d;
  logic [NUM_CHANNELS*TS_WIDTH-1:0] cap_val_q, cap_val_d;

  assign counter_val = TS_WIDTH'(body_q) << DROP_BITS;

`ifdef STAMP_CAP_SYNC_EN
  logic [NUM_CHANNELS-1:0] req_s1_q, req_s1_d;
  logic [NUM_CHANNELS-1:0] req_s2_q, req_s2_d;

  always_comb begin
    req_s1_d = cap_req;
    req_s2_d = req_s1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_s1_q <= '0;
      req_s2_q <= '0;
    end else begin
      req_s1_q <= req_s1_d;
      req_s2_q <= req_s2_d;
    end
  end

  assign req_s = req_s2_q;
`else
  assign req_s = cap_req;
`endif

  always_comb begin
    sum    = phase_add(acc_q, rate_q);
    acc_d  = sum[ACC_WIDTH-1:0];
    body_d = body_q + BODY_W'(sum[ACC_WIDTH]);
    rate_d = rate_valid ? rate_in : rate_q;
    if (load_valid) begin
      body_d = BODY_W'(load_time >> DROP_BITS);
      acc_d  = '0;
    end
  end

  // A load in the sync-point cycle restarts the period and swallows that pulse.
  always_comb begin
    at_sync      = (scnt_q == SYNC_LAST);
    scnt_d       = (at_sync || load_valid) ? '0 : scnt_q + SCNT_W'(1);
    sync_valid_d = at_sync && !load_valid;
    sync_time_d  = sync_valid_d ? counter_val : sync_time_q;
  end

  always_comb begin
    req_prev_d  = req_s;
    cap_edge    = req_s & ~req_prev_q;
    cap_valid_d = cap_valid_q;
    cap_val_d   = cap_val_q;
    cap_ovr_d   = cap_ovr_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cap_edge[i]) begin
        if (!cap_valid_q[i] || cap_ack[i]) begin
          cap_val_d[i*TS_WIDTH +: TS_WIDTH] = counter_val;
          cap_valid_d[i]                    = 1'b1;
          cap_ovr_d[i]                      = 1'b0;
        end else begin
          // Oldest capture is kept; the new edge only raises the sticky flag.
          cap_ovr_d[i] = 1'b1;
        end
      end else if (cap_ack[i] && cap_valid_q[i]) begin
        cap_valid_d[i] = 1'b0;
        cap_ovr_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      body_q       <= '0;
      acc_q        <= '0;
      rate_q       <= RATE_INIT;
      scnt_q       <= '0;
      sync_valid_q <= 1'b0;
      sync_time_q  <= '0;
      req_prev_q   <= '0;
      cap_valid_q  <= '0;
      cap_val_q    <= '0;
      cap_ovr_q    <= '0;
    end else begin
      body_q       <= body_d;
      acc_q        <= acc_d;
      rate_q       <= rate_d;
      scnt_q       <= scnt_d;
      sync_valid_q <= sync_valid_d;
      sync_time_q  <= sync_time_d;
      req_prev_q   <= req_prev_d;
      cap_valid_q  <= cap_valid_d;
      cap_val_q    <= cap_val_d;
      cap_ovr_q    <= cap_ovr_d;
    end
  end

  assign sync_valid  = sync_valid_q;
  assign sync_time   = sync_time_q;
  assign cap_valid   = cap_valid_q;
  assign cap_val     = cap_val_q;
  assign cap_overrun = cap_ovr_q;

endmodule

// File: tb/tb_stamp_counter_mc.sv
// Scoreboard bench for stamp_counter_mc: stimulus queues cycle-stamped expectations, a monitor compares them.
module tb_stamp_counter_mc;

  localparam int TSW = 64;
  localparam int NCH = 4;
`ifdef STAMP_CAP_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 load_valid;
  logic [TSW-1:0]       load_time;
  logic                 rate_valid;
  logic [31:0]          rate_in;
  logic [TSW-1:0]       counter_val;
  logic                 sync_valid;
  logic [TSW-1:0]       sync_time;
  logic [NCH-1:0]       cap_req;
  logic [NCH-1:0]       cap_ack;
  logic [NCH-1:0]       cap_valid;
  logic [NCH*TSW-1:0]   cap_val;
  logic [NCH-1:0]       cap_overrun;

  stamp_counter_mc #(
    .TS_WIDTH(64), .DROP_BITS(6), .ACC_WIDTH(32), .RATE_INIT(32'h80000000),
    .SYNC_PERIOD(10), .NUM_CHANNELS(NCH)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_time(load_time),
    .rate_valid(rate_valid), .rate_in(rate_in), .counter_val(counter_val),
    .sync_valid(sync_valid), .sync_time(sync_time), .cap_req(cap_req),
    .cap_ack(cap_ack), .cap_valid(cap_valid), .cap_val(cap_val),
    .cap_overrun(cap_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sel; logic [63:0] val; } exp_t;
  exp_t tq[$];
  exp_t sq[$];
  int   checks = 0;
  int   errors = 0;
  bit   sync_mon_en = 1'b0;

  localparam int S_CNT = 0, S_CVLD = 1, S_OVR = 2, S_SVLD = 3, S_STIME = 4, S_CVAL = 10;

  function automatic logic [63:0] probe(input int sel);
    case (sel)
      S_CNT:   return counter_val;
      S_CVLD:  return 64'(cap_valid);
      S_OVR:   return 64'(cap_overrun);
      S_SVLD:  return 64'(sync_valid);
      S_STIME: return sync_time;
      default: return cap_val[(sel-S_CVAL)*TSW +: TSW];
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_CNT:   return "counter_val";
      S_CVLD:  return "cap_valid";
      S_OVR:   return "cap_overrun";
      S_SVLD:  return "sync_valid";
      S_STIME: return "sync_time";
      default: return $sformatf("cap_val[%0d]", sel - S_CVAL);
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [63:0] v);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v;
    tq.push_back(e);
  endtask

  task automatic expect_sync(input int c, input logic [63:0] v);
    exp_t e;
    e.cyc = c; e.sel = S_STIME; e.val = v;
    sq.push_back(e);
  endtask

  // Monitor: compares due expectations and every observed sync pulse.
  always @(negedge clk) begin
    logic [63:0] got;
    exp_t        e;
    for (int i = tq.size() - 1; i >= 0; i--) begin
      if (tq[i].cyc == cyc) begin
        checks++;
        got = probe(tq[i].sel);
        if (got !== tq[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sel_name(tq[i].sel), cyc, got, tq[i].val);
        end
        tq.delete(i);
      end
    end
    if (sync_mon_en && sync_valid === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL sync_pulse cyc=%0d got=unexpected pulse want=none", cyc);
      end else begin
        e = sq.pop_front();
        if (e.cyc != cyc || sync_time !== e.val) begin
          errors++;
          $display("FAIL sync_pulse got cyc=%0d time=%h want cyc=%0d time=%h",
                   cyc, sync_time, e.cyc, e.val);
        end
      end
    end
  end

  task automatic chk_now(input string nm, input logic [NCH*TSW-1:0] got,
                         input logic [NCH*TSW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(input bit ld, input logic [63:0] lt, input bit rv, input logic [31:0] ri);
    load_valid = ld; load_time = lt; rate_valid = rv; rate_in = ri;
    @(negedge clk);
    load_valid = 1'b0; rate_valid = 1'b0;
  endtask

  initial begin
    int t, r, l, a, w, z, s, c, e, f;
    reset = 1'b0; load_valid = 1'b0; load_time = '0; rate_valid = 1'b0; rate_in = '0;
    cap_req = '0; cap_ack = '0;
    repeat (3) @(negedge clk);

    // reset state
    t = cyc;
    expect_at(t+1, S_CNT, 64'h0);
    expect_at(t+1, S_SVLD, 64'h0);
    expect_at(t+1, S_STIME, 64'h0);
    expect_at(t+1, S_CVLD, 64'h0);
    expect_at(t+1, S_OVR, 64'h0);
    expect_at(t+1, S_CVAL+0, 64'h0);
    wait_to(t+2);

    // release, RATE_INIT: one body step every two cycles
    reset = 1'b1; r = cyc;
    expect_at(r+1, S_CNT, 64'h0);
    expect_at(r+2, S_CNT, 64'h40);
    expect_at(r+3, S_CNT, 64'h40);
    expect_at(r+4, S_CNT, 64'h80);
    wait_to(r+5);

    // absolute load drops the LSBs
    l = cyc;
    expect_at(l+1, S_CNT, 64'h0000_0001_0000_0FC0);
    expect_at(l+2, S_CNT, 64'h0000_0001_0000_0FC0);
    expect_at(l+3, S_CNT, 64'h0000_0001_0000_1000);
    drive(1'b1, 64'h0000_0001_0000_0FFF, 1'b0, 32'h0);
    wait_to(l+4);

    // maximum rate
    a = cyc;
    expect_at(a+1, S_CNT, 64'h100);
    expect_at(a+2, S_CNT, 64'h100);
    expect_at(a+3, S_CNT, 64'h140);
    expect_at(a+4, S_CNT, 64'h180);
    expect_at(a+5, S_CNT, 64'h1C0);
    drive(1'b1, 64'h100, 1'b1, 32'hFFFF_FFFF);
    wait_to(a+6);

    // all-ones body wraps to zero on the next carry
    w = cyc;
    expect_at(w+1, S_CNT, 64'hFFFF_FFFF_FFFF_FFC0);
    expect_at(w+2, S_CNT, 64'hFFFF_FFFF_FFFF_FFC0);
    expect_at(w+3, S_CNT, 64'h0);
    expect_at(w+4, S_CNT, 64'h40);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h0);
    wait_to(w+5);

    // rate zero freezes the counter
    z = cyc;
    for (int k = 1; k <= 100; k += 9) expect_at(z+k, S_CNT, 64'h5555_0000_0000_1200);
    drive(1'b1, 64'h5555_0000_0000_1234, 1'b1, 32'h0);
    wait_to(z+101);

    // sync pulses every 10 cycles; a load at the sync point suppresses one
    s = cyc;
    drive(1'b1, 64'h2000, 1'b1, 32'h8000_0000);
    sync_mon_en = 1'b1;
    expect_sync(s+11, 64'h2100);
    expect_sync(s+21, 64'h2240);
    expect_sync(s+31, 64'h2380);
    expect_sync(s+51, 64'h4100);
    expect_at(s+10, S_CNT, 64'h2100);
    expect_at(s+12, S_SVLD, 64'h0);
    expect_at(s+41, S_SVLD, 64'h0);
    expect_at(s+52, S_SVLD, 64'h0);
    wait_to(s+40);
    drive(1'b1, 64'h4000, 1'b0, 32'h0);
    wait_to(s+53);
    sync_mon_en = 1'b0;
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL sync_missing got=%0d pending want=0", sq.size());
    end

    // channel 0 handshake with a frozen counter
    c = cyc;
    drive(1'b1, 64'h1000, 1'b1, 32'h0);
    wait_to(c+2);
    cap_req[0] = 1'b1;
    expect_at(c+3+D, S_CVLD, 64'h1);
    expect_at(c+3+D, S_CVAL+0, 64'h1000);
    expect_at(c+3+D, S_OVR, 64'h0);
    wait_to(c+5);
    cap_req[0] = 1'b0;
    wait_to(c+6);
    drive(1'b1, 64'h3000, 1'b0, 32'h0);
    cap_req[0] = 1'b1;
    expect_at(c+8+D, S_OVR, 64'h1);
    expect_at(c+8+D, S_CVLD, 64'h1);
    expect_at(c+8+D, S_CVAL+0, 64'h1000);
    wait_to(c+10);
    cap_req[0] = 1'b0;
    wait_to(c+14);
    cap_ack[0] = 1'b1;
    @(negedge clk);
    cap_ack[0] = 1'b0;
    expect_at(c+15, S_CVLD, 64'h0);
    expect_at(c+15, S_OVR, 64'h0);
    wait_to(c+16);
    cap_req[0] = 1'b1;
    expect_at(c+17+D, S_CVLD, 64'h1);
    expect_at(c+17+D, S_CVAL+0, 64'h3000);
    wait_to(c+20);
    cap_req[0] = 1'b0;
    drive(1'b1, 64'h5000, 1'b0, 32'h0);
    wait_to(c+22);
    cap_req[0] = 1'b1;
    wait_to(c+22+D);
    cap_ack[0] = 1'b1;
    expect_at(c+23+D, S_CVAL+0, 64'h5000);
    expect_at(c+23+D, S_CVLD, 64'h1);
    expect_at(c+23+D, S_OVR, 64'h0);
    @(negedge clk);
    cap_ack[0] = 1'b0;
    wait_to(c+26);

    // simultaneous edges on channels 1 and 3
    e = cyc;
    cap_req = 4'b1011;
    expect_at(e+1+D, S_CVLD, 64'hB);
    expect_at(e+1+D, S_CVAL+1, 64'h5000);
    expect_at(e+1+D, S_CVAL+3, 64'h5000);
    expect_at(e+1+D, S_CVAL+2, 64'h0);
    expect_at(e+1+D, S_OVR, 64'h0);
    wait_to(e+4);

    // asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk_now("async_cap_valid", (NCH*TSW)'(cap_valid), '0);
    chk_now("async_cap_val", cap_val, '0);
    chk_now("async_cap_overrun", (NCH*TSW)'(cap_overrun), '0);
    chk_now("async_counter_val", (NCH*TSW)'(counter_val), '0);
    chk_now("async_sync_time", (NCH*TSW)'(sync_time), '0);
    cap_req = '0;
    @(negedge clk);
    reset = 1'b1; f = cyc;
    expect_at(f+1, S_CNT, 64'h0);
    expect_at(f+1, S_CVLD, 64'h0);
    expect_at(f+2, S_CNT, 64'h40);
    expect_at(f+4, S_CNT, 64'h80);
    wait_to(f+6);

    checks++;
    if (tq.size() != 0) begin
      errors++;
      $display("FAIL unchecked_expectations got=%0d pending want=0", tq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
